axis_counter_source: RTL and testbench

Parametrised AXI4-Stream master that generates framed packets of incrementing counter data, with a full valid/ready handshake. It is the next-generation stimulus source for the stream datapath. It adds the following over the fixed 16-bit generator:
- configurable width, packet length and inter-packet gap;
- a restart/continue data mode;
- a start-of-packet marker;
- a packet-count limit with a done flag;
- correct data hold under back-pressure.

---
 rtl/axis_counter_source.sv | 145 ++++++++++++++
 tb/tb_axis_counter_source.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/axis_counter_source.sv
// AXI4-Stream master emitting framed packets of incrementing counter data,
// with configurable length, inter-packet gap, data mode and packet limit.
module axis_counter_source #(
  parameter int DATA_W     = 16,
  parameter int START_VAL  = 800,
  parameter int PKT_LEN    = 9,
  parameter int GAP_CYCLES = 0,
  parameter int NUM_PKTS   = 0,
  parameter int MODE       = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic              m_tuser,
  output logic [15:0]       pkt_count,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int BEAT_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [DATA_W-1:0] START_DATA = DATA_W'(START_VAL);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(PKT_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_INIT   = GAP_W'(GAP_LOAD);
  localparam logic [15:0]       NUM_LIMIT  = 16'(NUM_PKTS);
  localparam logic              SINGLE     = (PKT_LEN == 1);

  logic [1:0]        r_state;
  logic [BEAT_W-1:0] r_beat;
  logic [GAP_W-1:0]  r_gap;
  logic [DATA_W-1:0] r_acc;

  logic              w_xfer;
  logic              w_last;
  logic [BEAT_W-1:0] w_beat_inc;
  logic [DATA_W-1:0] w_acc_inc;
  logic [DATA_W-1:0] w_acc_next_pkt;
  logic [15:0]       w_cnt_inc;

  assign w_xfer         = m_tvalid && m_tready;
  assign w_last         = (r_beat == LAST_BEAT);
  assign w_beat_inc     = r_beat + 1'b1;
  assign w_acc_inc      = r_acc + 1'b1;
  assign w_acc_next_pkt = (MODE != 0) ? w_acc_inc : START_DATA;
  assign w_cnt_inc      = pkt_count + 16'd1;

  // r_acc always holds the value of the beat being (or about to be) presented.
  // NOTE: non-blocking assignments keep every register update on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_beat    <= '0;
      r_gap     <= '0;
      r_acc     <= START_DATA;
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tlast   <= 1'b0;
      m_tuser   <= 1'b0;
      pkt_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable && !done) begin
            r_state  <= S_SEND;
            busy     <= 1'b1;
            r_beat   <= '0;
            m_tvalid <= 1'b1;
            m_tdata  <= r_acc;
            m_tuser  <= 1'b1;
            m_tlast  <= SINGLE;
          end
        end
        S_SEND: begin
          if (w_xfer && !w_last) begin
            r_beat  <= w_beat_inc;
            r_acc   <= w_acc_inc;
            m_tdata <= w_acc_inc;
            m_tuser <= 1'b0;
            m_tlast <= (w_beat_inc == LAST_BEAT);
          end else if (w_xfer) begin
            pkt_count <= w_cnt_inc;
            r_acc     <= w_acc_next_pkt;
            r_beat    <= '0;
            if (NUM_PKTS != 0 && w_cnt_inc == NUM_LIMIT) begin
              r_state  <= S_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              m_tvalid <= 1'b0;
              m_tuser  <= 1'b0;
              m_tlast  <= 1'b0;
            end else if (GAP_CYCLES > 0) begin
              r_state  <= S_GAP;
              r_gap    <= GAP_INIT;
              m_tvalid <= 1'b0;
              m_tuser  <= 1'b0;
              m_tlast  <= 1'b0;
            end else if (enable) begin
              m_tdata <= w_acc_next_pkt;
              m_tuser <= 1'b1;
              m_tlast <= SINGLE;
            end else begin
              r_state  <= S_IDLE;
              busy     <= 1'b0;
              m_tvalid <= 1'b0;
              m_tuser  <= 1'b0;
              m_tlast  <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
          end else if (enable) begin
            r_state  <= S_SEND;
            m_tvalid <= 1'b1;
            m_tdata  <= r_acc;
            m_tuser  <= 1'b1;
            m_tlast  <= SINGLE;
          end else begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_counter_source.sv
// Directed bench for axis_counter_source: three instances cover the default,
// wrapping/limited MODE=1, and single-beat-with-gap configurations.
module tb_axis_counter_source;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Default instance
  logic        en0 = 1'b0, tr0 = 1'b0;
  logic        v0, l0, u0, b0, d0;
  logic [15:0] dat0, pc0;
  axis_counter_source dut0 (
    .clk(clk), .resetn(resetn), .enable(en0), .m_tvalid(v0), .m_tready(tr0),
    .m_tdata(dat0), .m_tlast(l0), .m_tuser(u0), .pkt_count(pc0), .busy(b0), .done(d0)
  );

  // MODE 1, 8-bit wrap, two-packet limit
  logic        en1 = 1'b0, tr1 = 1'b0;
  logic        v1, l1, u1, b1, d1;
  logic [7:0]  dat1;
  logic [15:0] pc1;
  axis_counter_source #(.DATA_W(8), .START_VAL(250), .PKT_LEN(4), .NUM_PKTS(2), .MODE(1)) dut1 (
    .clk(clk), .resetn(resetn), .enable(en1), .m_tvalid(v1), .m_tready(tr1),
    .m_tdata(dat1), .m_tlast(l1), .m_tuser(u1), .pkt_count(pc1), .busy(b1), .done(d1)
  );

  // Single-beat packets separated by a 3-cycle gap
  logic        en2 = 1'b0, tr2 = 1'b0;
  logic        v2, l2, u2, b2, d2;
  logic [15:0] dat2, pc2;
  axis_counter_source #(.PKT_LEN(1), .GAP_CYCLES(3)) dut2 (
    .clk(clk), .resetn(resetn), .enable(en2), .m_tvalid(v2), .m_tready(tr2),
    .m_tdata(dat2), .m_tlast(l2), .m_tuser(u2), .pkt_count(pc2), .busy(b2), .done(d2)
  );

  int exp1 [8] = '{250, 251, 252, 253, 254, 255, 0, 1};

  initial begin
    step();
    step();
    check("rst_tvalid", 32'(v0), 0);
    check("rst_tdata", 32'(dat0), 0);
    check("rst_tlast_tuser", 32'({l0, u0}), 0);
    check("rst_cnt_busy_done", 32'({pc0, b0, d0}), 0);
    resetn = 1'b1;
    step();

    // Back-to-back packets with tready held high
    en0 = 1'b1;
    tr0 = 1'b1;
    step();
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 9; b++) begin
        check("b2b_tvalid", 32'(v0), 1);
        check("b2b_tdata", 32'(dat0), 32'(800 + b));
        check("b2b_tuser", 32'(u0), 32'(b == 0));
        check("b2b_tlast", 32'(l0), 32'(b == 8));
        step();
      end
      check("b2b_pkt_count", 32'(pc0), 32'(p + 1));
      check("b2b_busy", 32'(b0), 1);
    end

    // Back-pressure: each beat offered once with tready low, then accepted
    for (int b = 0; b < 9; b++) begin
      tr0 = 1'b0;
      check("bp_tvalid", 32'(v0), 1);
      check("bp_tdata", 32'(dat0), 32'(800 + b));
      step();
      tr0 = 1'b1;
      check("bp_hold_tvalid", 32'(v0), 1);
      check("bp_hold_tdata", 32'(dat0), 32'(800 + b));
      check("bp_hold_tuser", 32'(u0), 32'(b == 0));
      check("bp_hold_tlast", 32'(l0), 32'(b == 8));
      step();
    end
    check("bp_pkt_count", 32'(pc0), 3);

    // Drop enable mid-packet: packet must still complete
    for (int b = 0; b < 9; b++) begin
      check("drop_tvalid", 32'(v0), 1);
      check("drop_tdata", 32'(dat0), 32'(800 + b));
      if (b == 3) en0 = 1'b0;
      step();
    end
    check("drop_idle_tvalid", 32'(v0), 0);
    check("drop_idle_busy", 32'(b0), 0);
    check("drop_idle_tlast_tuser", 32'({l0, u0}), 0);
    check("drop_pkt_count", 32'(pc0), 4);
    step();
    check("drop_idle_hold", 32'(v0), 0);
    en0 = 1'b1;
    step();
    check("reen_tvalid", 32'(v0), 1);
    check("reen_tdata", 32'(dat0), 800);
    check("reen_tuser", 32'(u0), 1);

    // Asynchronous reset while a beat is stalled
    step();
    step();
    tr0 = 1'b0;
    step();
    check("stall_tdata", 32'(dat0), 802);
    check("stall_tvalid", 32'(v0), 1);
    resetn = 1'b0;
    #1;
    check("arst_tvalid", 32'(v0), 0);
    check("arst_tdata", 32'(dat0), 0);
    check("arst_tlast_tuser", 32'({l0, u0}), 0);
    check("arst_cnt_busy_done", 32'({pc0, b0, d0}), 0);
    step();
    resetn = 1'b1;
    tr0 = 1'b1;
    step();
    check("post_rst_tvalid", 32'(v0), 1);
    check("post_rst_tdata", 32'(dat0), 800);
    check("post_rst_tuser", 32'(u0), 1);
    check("post_rst_pkt_count", 32'(pc0), 0);
    en0 = 1'b0;

    // MODE 1 with data wrap and two-packet limit
    en1 = 1'b1;
    tr1 = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      check("m1_tvalid", 32'(v1), 1);
      check("m1_tdata", 32'(dat1), 32'(exp1[i]));
      check("m1_tuser", 32'(u1), 32'(i % 4 == 0));
      check("m1_tlast", 32'(l1), 32'(i % 4 == 3));
      step();
    end
    check("m1_done", 32'(d1), 1);
    check("m1_tvalid_off", 32'(v1), 0);
    check("m1_pkt_count", 32'(pc1), 2);
    check("m1_busy", 32'(b1), 0);
    en1 = 1'b0;
    step();
    en1 = 1'b1;
    step();
    step();
    check("m1_enable_ignored", 32'(v1), 0);
    check("m1_done_sticky", 32'(d1), 1);
    en1 = 1'b0;

    // Single-beat packets with a 3-cycle gap
    en2 = 1'b1;
    tr2 = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      check("gap_beat_tvalid", 32'(v2), 1);
      check("gap_beat_tuser_tlast", 32'({u2, l2}), 3);
      check("gap_beat_tdata", 32'(dat2), 800);
      step();
      for (int g = 0; g < 3; g++) begin
        check("gap_idle_tvalid", 32'(v2), 0);
        check("gap_busy", 32'(b2), 1);
        step();
      end
    end
    check("gap_resume_tvalid", 32'(v2), 1);
    check("gap_pkt_count", 32'(pc2), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
